// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic-array edge datapath.
package sa_pkg;

    localparam int DEF_REG_WIDTH = 16;
    localparam int DEF_LANES     = 8;

    typedef logic [DEF_REG_WIDTH-1:0] elem_t;

    typedef enum logic {
        SKEW   = 1'b0,
        DESKEW = 1'b1
    } skew_mode_e;

    // Lane latency: skew ramps up with lane index, de-skew ramps down.
    function automatic int lane_depth(int base, int lanes, int idx, skew_mode_e m);
        return (m == DESKEW) ? base + (lanes - 1 - idx) : base + idx;
    endfunction

endpackage

// File: rtl/delay_lane.sv
// One lane of the skew line: MAXD-deep {valid, a, b} shift register with a runtime tap.
module delay_lane
    import sa_pkg::*;
#(
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int MAXD      = 8,
    parameter int TW        = $clog2(MAXD + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [REG_WIDTH-1:0] a_i,
    input  logic [REG_WIDTH-1:0] b_i,
    input  logic [TW-1:0]        tap_i,
    output logic                 valid_o,
    output logic [REG_WIDTH-1:0] a_o,
    output logic [REG_WIDTH-1:0] b_o,
    output logic                 busy_o
);

    // Stage k holds what entered k enabled edges ago; stage 0 is the input itself.
    logic [MAXD:1]                vld_q;
    logic [MAXD:1][REG_WIDTH-1:0] a_q;
    logic [MAXD:1][REG_WIDTH-1:0] b_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            if (flush_i)
                vld_q <= '0;
            else if (en_i)
                vld_q <= {vld_q[MAXD-1:1], valid_i};
            if (en_i) begin
                a_q <= {a_q[MAXD-1:1], a_i};
                b_q <= {b_q[MAXD-1:1], b_i};
            end
        end
    end

    assign valid_o = vld_q[tap_i];
    assign a_o     = valid_o ? a_q[tap_i] : '0;
    assign b_o     = valid_o ? b_q[tap_i] : '0;

    // Only stages up to the tap can still reach the output.
    always_comb begin
        busy_o = 1'b0;
        for (int k = 1; k <= MAXD; k++)
            if (k <= int'(tap_i) && vld_q[k])
                busy_o = 1'b1;
    end

endmodule

// File: rtl/skew_delay_line.sv
// Two-operand vector delay line producing triangular skew or de-skew at the PE-grid edges.
module skew_delay_line
    import sa_pkg::*;
#(
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int LANES      = DEF_LANES,
    parameter int BASE_DELAY = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             flush,
    input  logic                             mode_req,
    input  logic                             in_valid,
    input  logic [LANES-1:0][REG_WIDTH-1:0]  a_in,
    input  logic [LANES-1:0][REG_WIDTH-1:0]  b_in,
    output logic [LANES-1:0]                 lane_valid,
    output logic [LANES-1:0][REG_WIDTH-1:0]  a_out,
    output logic [LANES-1:0][REG_WIDTH-1:0]  b_out,
    output logic                             busy,
    output logic                             mode,
    output logic                             mode_err
);

    localparam int MAXD = BASE_DELAY + LANES - 1;
    localparam int TW   = $clog2(MAXD + 1);

    skew_mode_e       mode_q, mode_d;
    logic             err_q, err_d;
    logic [LANES-1:0] lane_busy;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [TW-1:0] tap;
        assign tap = TW'(lane_depth(BASE_DELAY, LANES, i, mode_q));

        delay_lane #(
            .REG_WIDTH (REG_WIDTH),
            .MAXD      (MAXD),
            .TW        (TW)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en_i    (en),
            .flush_i (flush),
            .valid_i (in_valid),
            .a_i     (a_in[i]),
            .b_i     (b_in[i]),
            .tap_i   (tap),
            .valid_o (lane_valid[i]),
            .a_o     (a_out[i]),
            .b_o     (b_out[i]),
            .busy_o  (lane_busy[i])
        );
    end

    assign busy = |lane_busy;

    // Re-tapping with data in flight (or entering) would tear vectors, so switch only when idle.
    always_comb begin
        mode_d = mode_q;
        err_d  = 1'b0;
        if (busy || in_valid)
            err_d = (skew_mode_e'(mode_req) != mode_q);
        else
            mode_d = skew_mode_e'(mode_req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= SKEW;
            err_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            err_q  <= err_d;
        end
    end

    assign mode     = mode_q;
    assign mode_err = err_q;

endmodule

// File: tb/tb_skew_delay_line.sv
// Randomised bench for skew_delay_line against a queue-of-vectors timing model.
module tb_skew_delay_line;

    localparam int W    = 16;
    localparam int L    = 8;
    localparam int BASE = 1;
    localparam int MAXD = BASE + L - 1;
    localparam int OW   = L + 2 * L * W + 3;

    logic clk = 1'b0;
    logic rst, en, flush, mode_req, in_valid;
    logic [L-1:0][W-1:0] a_in, b_in, a_out, b_out;
    logic [L-1:0] lane_valid;
    logic busy, mode, mode_err;

    logic [OW-1:0] obs, expv;
    assign obs = {lane_valid, a_out, b_out, busy, mode, mode_err};

    int total = 0;
    int bad   = 0;

    // Each accepted vector is tracked by how many enabled edges it has aged.
    typedef struct {
        int                  age;
        logic [L-1:0][W-1:0] a;
        logic [L-1:0][W-1:0] b;
    } vec_t;

    vec_t m_q[$];
    logic m_mode = 1'b0;
    logic m_err  = 1'b0;
    logic last_en = 1'b0;

    skew_delay_line #(.REG_WIDTH(W), .LANES(L), .BASE_DELAY(BASE)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .mode_req(mode_req),
        .in_valid(in_valid), .a_in(a_in), .b_in(b_in), .lane_valid(lane_valid),
        .a_out(a_out), .b_out(b_out), .busy(busy), .mode(mode), .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    task automatic model_out();
        logic [L-1:0][W-1:0] ea, eb;
        logic [L-1:0] lv;
        int d;
        lv = '0; ea = '0; eb = '0;
        for (int i = 0; i < L; i++) begin
            d = BASE + (m_mode ? L - 1 - i : i);
            foreach (m_q[j])
                if (m_q[j].age == d) begin
                    lv[i] = 1'b1;
                    ea[i] = m_q[j].a[i];
                    eb[i] = m_q[j].b[i];
                end
        end
        expv = {lv, ea, eb, (m_q.size() != 0), m_mode, m_err};
    endtask

    task automatic model_rst();
        m_q.delete();
        m_mode = 1'b0;
        m_err  = 1'b0;
        model_out();
    endtask

    task automatic drive(input logic v, input logic e, input logic f, input logic mr);
        in_valid = v; en = e; flush = f; mode_req = mr;
        for (int i = 0; i < L; i++) begin
            a_in[i] = W'($urandom);
            b_in[i] = W'($urandom);
        end
    endtask

    // One clock: advance the model from the inputs seen at the edge, then sample #1 later.
    task automatic tick();
        logic hold;
        vec_t v;
        hold    = (m_q.size() != 0) || in_valid;
        last_en = en;
        @(posedge clk);
        m_err = (mode_req != m_mode) && hold;
        if (!hold) m_mode = mode_req;
        if (flush) m_q.delete();
        else if (en) begin
            foreach (m_q[j]) m_q[j].age = m_q[j].age + 1;
            while (m_q.size() > 0 && m_q[0].age > MAXD) void'(m_q.pop_front());
            if (in_valid) begin
                v.age = 1; v.a = a_in; v.b = b_in;
                m_q.push_back(v);
            end
        end
        #1;
        model_out();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        model_rst();
        repeat (2) @(posedge clk);
        #1;
        total++; if (obs !== '0) begin bad++; $display("FAIL reset_idle got=%h exp=0", obs); end
        @(negedge clk); rst = 1'b0;
        drive(0, 1, 0, 1); tick();
        total++; if (mode !== 1'b1 || obs !== expv) begin bad++; $display("FAIL reset_mode_set got=%h exp=%h", obs, expv); end
        for (int n = 0; n < 3; n++) begin drive(1, 1, 0, 1); tick(); end
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_inflight busy=%b exp=1", busy); end
        #2 rst = 1'b1;
        #1 model_rst();
        total++; if (obs !== '0) begin bad++; $display("FAIL reset_async got=%h exp=0", obs); end
        @(negedge clk); rst = 1'b0;
        drive(0, 1, 0, 0);
        for (int c = 0; c < 12; c++) begin
            tick();
            total++;
            if (obs !== expv || lane_valid !== '0) begin bad++; $display("FAIL reset_resurface c=%0d got=%h exp=%h", c, obs, expv); end
        end
    endtask

    task automatic test_skew();
        logic [L-1:0] one, el;
        one = 1;
        drive(0, 1, 0, 0); tick(); tick();
        drive(1, 1, 0, 0);
        for (int i = 0; i < L; i++) a_in[i] = W'(16'h0100 + i);
        for (int k = 1; k <= L + 2; k++) begin
            tick(); in_valid = 1'b0;
            el = (k <= L) ? one << (k - 1) : '0;
            total++; if (obs !== expv) begin bad++; $display("FAIL skew_model k=%0d got=%h exp=%h", k, obs, expv); end
            total++;
            if (lane_valid !== el || busy !== (k <= L)) begin
                bad++; $display("FAIL skew_lane k=%0d lv=%b busy=%b exp_lv=%b exp_busy=%b", k, lane_valid, busy, el, (k <= L));
            end
            if (k <= L) begin
                total++;
                if (a_out[k-1] !== W'(16'h0100 + k - 1)) begin bad++; $display("FAIL skew_data k=%0d got=%h exp=%h", k, a_out[k-1], W'(16'h0100 + k - 1)); end
            end
        end
    endtask

    task automatic test_stall();
        int first[L];
        int cnt[L];
        logic [OW-1:0] snap;
        for (int i = 0; i < L; i++) begin first[i] = -1; cnt[i] = 0; end
        snap = '0;
        drive(1, 1, 0, 0);
        for (int i = 0; i < L; i++) a_in[i] = W'(16'h0200 + i);
        for (int c = 0; c < 16; c++) begin
            en = !(c >= 2 && c <= 4);
            tick(); in_valid = 1'b0;
            total++; if (obs !== expv) begin bad++; $display("FAIL stall_model c=%0d got=%h exp=%h", c, obs, expv); end
            if (!last_en) begin
                total++; if (obs !== snap) begin bad++; $display("FAIL stall_hold c=%0d got=%h exp=%h", c, obs, snap); end
            end else begin
                snap = obs;
                for (int i = 0; i < L; i++)
                    if (lane_valid[i]) begin
                        cnt[i]++;
                        if (first[i] < 0) first[i] = c + 1;
                    end
            end
        end
        for (int i = 0; i < L; i++) begin
            total++;
            if (cnt[i] !== 1 || first[i] !== (i < 2 ? i + 1 : i + 4)) begin
                bad++; $display("FAIL stall_lane%0d count=%0d edge=%0d exp_count=1 exp_edge=%0d", i, cnt[i], first[i], (i < 2 ? i + 1 : i + 4));
            end
        end
    endtask

    task automatic test_flush();
        drive(0, 1, 0, 0); tick();
        for (int c = 0; c < 14; c++) begin
            drive(c < 4, 1, c == 3, 0);
            tick();
            total++; if (obs !== expv) begin bad++; $display("FAIL flush_model c=%0d got=%h exp=%h", c, obs, expv); end
            if (c >= 3) begin
                total++;
                if (lane_valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL flush_clear c=%0d lv=%b busy=%b exp=0", c, lane_valid, busy); end
            end
        end
    endtask

    task automatic test_mode();
        logic [L-1:0] one;
        int c;
        one = 1;
        drive(1, 1, 0, 0); tick();
        drive(0, 1, 0, 1); tick();
        total++; if (obs !== expv || mode_err !== 1'b1 || mode !== 1'b0) begin bad++; $display("FAIL mode_busy_err got=%h exp=%h", obs, expv); end
        drive(0, 1, 0, 0); tick();
        total++; if (obs !== expv || mode_err !== 1'b0) begin bad++; $display("FAIL mode_err_pulse err=%b exp=0", mode_err); end
        drive(0, 0, 0, 1); tick();
        total++; if (obs !== expv || mode_err !== 1'b1 || mode !== 1'b0) begin bad++; $display("FAIL mode_repeat_err got=%h exp=%h", obs, expv); end
        drive(0, 1, 0, 0);
        c = 0;
        while (busy && c < 20) begin
            tick(); c++;
            total++; if (obs !== expv) begin bad++; $display("FAIL mode_drain_model c=%0d got=%h exp=%h", c, obs, expv); end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mode_drain busy=%b exp=0", busy); end
        drive(0, 0, 0, 1); tick();
        total++; if (obs !== expv || mode !== 1'b1 || mode_err !== 1'b0) begin bad++; $display("FAIL mode_switch mode=%b err=%b exp=1/0", mode, mode_err); end
        drive(1, 1, 0, 1);
        for (int i = 0; i < L; i++) b_in[i] = W'(16'hB000 + i);
        for (int k = 1; k <= L; k++) begin
            tick(); in_valid = 1'b0;
            total++;
            if (obs !== expv || lane_valid !== (one << (L - k)) || b_out[L-k] !== W'(16'hB000 + L - k)) begin
                bad++; $display("FAIL deskew k=%0d lv=%b b=%h exp_lv=%b exp_b=%h", k, lane_valid, b_out[L-k], one << (L - k), W'(16'hB000 + L - k));
            end
        end
        tick();
        drive(1, 1, 0, 0); tick();
        total++; if (obs !== expv || mode_err !== 1'b1 || mode !== 1'b1) begin bad++; $display("FAIL mode_inval_err mode=%b err=%b exp=1/1", mode, mode_err); end
        drive(0, 1, 1, 0); tick();
        total++; if (obs !== expv || mode_err !== 1'b1 || mode !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mode_flush_err got=%h exp=%h", obs, expv); end
        drive(0, 1, 0, 0); tick();
        total++; if (obs !== expv || mode !== 1'b0 || mode_err !== 1'b0) begin bad++; $display("FAIL mode_after_flush mode=%b err=%b exp=0/0", mode, mode_err); end
    endtask

    task automatic test_back_to_back();
        int n, guard;
        int nxt[L];
        logic [W-1:0] ev;
        n = 0; guard = 0;
        for (int i = 0; i < L; i++) nxt[i] = 0;
        drive(0, 1, 0, 0); tick();
        while ((n < 20 || m_q.size() != 0) && guard < 400) begin
            en = ($urandom_range(0, 3) != 0); flush = 1'b0; mode_req = 1'b0;
            in_valid = (n < 20);
            for (int i = 0; i < L; i++) begin
                a_in[i] = W'(n * 256 + i);
                b_in[i] = ~a_in[i];
            end
            tick(); guard++;
            if (last_en && in_valid) n++;
            total++; if (obs !== expv) begin bad++; $display("FAIL b2b_model g=%0d got=%h exp=%h", guard, obs, expv); end
            if (last_en)
                for (int i = 0; i < L; i++)
                    if (lane_valid[i]) begin
                        ev = W'(nxt[i] * 256 + i);
                        total++;
                        if (a_out[i] !== ev || b_out[i] !== ~ev) begin bad++; $display("FAIL b2b_lane%0d a=%h b=%h exp_a=%h exp_b=%h", i, a_out[i], b_out[i], ev, ~ev); end
                        nxt[i]++;
                    end
        end
        total++; if (guard >= 400) begin bad++; $display("FAIL b2b_timeout cycles=%0d limit=400", guard); end
        for (int i = 0; i < L; i++) begin
            total++; if (nxt[i] !== 20) begin bad++; $display("FAIL b2b_count lane%0d got=%0d exp=20", i, nxt[i]); end
        end
    endtask

    task automatic test_random();
        logic mr;
        mr = 1'b0;
        for (int c = 0; c < 250; c++) begin
            if ($urandom_range(0, 7) == 0) mr = ~mr;
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, mr);
            tick();
            total++; if (obs !== expv) begin bad++; $display("FAIL random c=%0d got=%h exp=%h", c, obs, expv); end
        end
    endtask

    initial begin
        test_reset();
        test_skew();
        test_stall();
        test_flush();
        test_mode();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
